reg_file_array: RTL and testbench

Parametrised register file with one write port and one registered read port. It generalises the fixed 8x8 flip-flop array and adds these features:
- independent simultaneous read and write;
- per-entry written tracking with a read-of-unwritten error;
- out-of-range address detection;
- bulk clear;
- a live count of valid entries.

It sits beside control/datapath blocks as a small configuration/scratch store.

---
 rtl/reg_file_array.sv | 120 ++++++++++++
 tb/tb_reg_file_array.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_array.sv
// Parametrised register file: one write port, one registered read port, per-entry valid tracking.
// Optional same-address write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  logic                       clr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       err_unwritten,
  output logic                       err_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_unw_q, err_unw_d;
  logic             err_addr_q, err_addr_d;

  logic wr_in_range_s, rd_in_range_s, wr_acc_s, byp_hit_s;

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
  // clr drops a same-cycle write, so a dropped write can never be bypassed either
  assign wr_acc_s      = wr_en && wr_in_range_s && !clr;

`ifdef REG_FILE_BYPASS_EN
  assign byp_hit_s = wr_acc_s && (wr_addr == rd_addr);
`else
  assign byp_hit_s = 1'b0;
`endif

  // Next storage, valid bits and entry count
  always_comb begin
    mem_d   = mem_q;
    vld_d   = vld_q;
    count_d = count_q;
    if (clr) begin
      vld_d   = '0;
      count_d = '0;
    end else if (wr_acc_s) begin
      mem_d[wr_addr] = wr_data;
      vld_d[wr_addr] = 1'b1;
      if (!vld_q[wr_addr]) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Next read response; reads observe pre-write, pre-clear state unless bypassed
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    err_unw_d  = 1'b0;
    err_addr_d = wr_en && !wr_in_range_s;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (!rd_in_range_s) begin
        err_addr_d = 1'b1;
      end else if (byp_hit_s) begin
        rd_data_d = wr_data;
      end else if (vld_q[rd_addr]) begin
        rd_data_d = mem_q[rd_addr];
      end else begin
        err_unw_d = 1'b1;
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q      <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_unw_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      vld_q      <= vld_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_unw_q  <= err_unw_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign err_unwritten = err_unw_q;
  assign err_addr      = err_addr_q;
  assign count         = count_q;

endmodule

// File: tb/tb_reg_file_array.sv
// Self-checking bench: DEPTH=8 and DEPTH=6 instances share stimulus, each checked against an array model.
module tb_reg_file_array;

  logic       clk = 1'b0;
  logic       resetn, wr_en, rd_en, clr;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  logic [7:0] rd_data8, rd_data6;
  logic       rd_valid8, rd_valid6, err_unw8, err_unw6, err_addr8, err_addr6;
  logic [3:0] count8;
  logic [2:0] count6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_array #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .rd_data(rd_data8), .rd_valid(rd_valid8),
    .err_unwritten(err_unw8), .err_addr(err_addr8), .count(count8));

  reg_file_array #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .rd_data(rd_data6), .rd_valid(rd_valid6),
    .err_unwritten(err_unw6), .err_addr(err_addr6), .count(count6));

  // Reference model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 instance
  int         dep [2] = '{8, 6};
  logic [7:0] m_mem [2][8];
  bit         m_vld [2][8];
  logic [7:0] e_data [2];
  bit         e_valid [2], e_unw [2], e_addr [2];
  int         e_count [2];

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      e_data[d] = 8'h00; e_valid[d] = 1'b0; e_unw[d] = 1'b0; e_addr[d] = 1'b0;
      if (!resetn) begin
        for (int a = 0; a < 8; a++) begin
          m_vld[d][a] = 1'b0;
          m_mem[d][a] = 8'h00;
        end
      end else begin
        e_valid[d] = rd_en;
        e_addr[d]  = wr_en && (int'(wr_addr) >= dep[d]);
        if (rd_en) begin
          if (int'(rd_addr) >= dep[d]) e_addr[d] = 1'b1;
          else if (BYPASS && wr_en && !clr && wr_addr == rd_addr) e_data[d] = wr_data;
          else if (m_vld[d][rd_addr]) e_data[d] = m_mem[d][rd_addr];
          else e_unw[d] = 1'b1;
        end
        if (clr) begin
          for (int a = 0; a < 8; a++) m_vld[d][a] = 1'b0;
        end else if (wr_en && int'(wr_addr) < dep[d]) begin
          m_vld[d][wr_addr] = 1'b1;
          m_mem[d][wr_addr] = wr_data;
        end
      end
      e_count[d] = 0;
      for (int a = 0; a < dep[d]; a++) e_count[d] += int'(m_vld[d][a]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d8_rd_data", 32'(rd_data8), 32'(e_data[0]));
    chk("d8_rd_valid", 32'(rd_valid8), 32'(e_valid[0]));
    chk("d8_err_unw", 32'(err_unw8), 32'(e_unw[0]));
    chk("d8_err_addr", 32'(err_addr8), 32'(e_addr[0]));
    chk("d8_count", 32'(count8), 32'(e_count[0]));
    chk("d6_rd_data", 32'(rd_data6), 32'(e_data[1]));
    chk("d6_rd_valid", 32'(rd_valid6), 32'(e_valid[1]));
    chk("d6_err_unw", 32'(err_unw6), 32'(e_unw[1]));
    chk("d6_err_addr", 32'(err_addr6), 32'(e_addr[1]));
    chk("d6_count", 32'(count6), 32'(e_count[1]));
  endtask

  task automatic drive(input bit rn, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                       input bit re, input logic [2:0] ra, input bit c);
    resetn = rn; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; clr = c;
  endtask

  // One clock: model follows the sampled inputs, DUT outputs checked 1 time unit after the edge
  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    #1;
    cycle();
    cycle();
    chk("reset_count8", 32'(count8), 32'd0);

    // Read of an unwritten entry right after reset
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0); cycle();
    chk("tp_unw_after_reset", 32'(err_unw8), 32'd1);

    drive(1'b1, 1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 1'b0); cycle();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0); cycle();
    chk("tp_read_a5", 32'(rd_data8), 32'h0000_00A5);
    drive(1'b1, 1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 1'b0); cycle();
    chk("tp_rewrite_count", 32'(count8), 32'd1);

    // Same-cycle write and read of a previously invalid entry, then read-back
    drive(1'b1, 1'b1, 3'd5, 8'h77, 1'b1, 3'd5, 1'b0); cycle();
    chk("tp_same_addr_data", 32'(rd_data8), BYPASS ? 32'h77 : 32'h0);
    chk("tp_same_addr_unw", 32'(err_unw8), BYPASS ? 32'd0 : 32'd1);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0); cycle();
    chk("tp_readback_77", 32'(rd_data8), 32'h77);

    // Fill every address, then clear with a same-cycle (dropped) write
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b1, 3'(a), 8'(8'h10 + a), 1'b1, 3'(7 - a), 1'b0); cycle();
    end
    chk("tp_full8", 32'(count8), 32'd8);
    chk("tp_full6", 32'(count6), 32'd6);
    drive(1'b1, 1'b1, 3'd0, 8'hEE, 1'b1, 3'd0, 1'b1); cycle();
    chk("tp_clr_count", 32'(count8), 32'd0);
    chk("tp_clr_read_pre", 32'(rd_data8), 32'h10);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0); cycle();
    chk("tp_clr_unw", 32'(err_unw8), 32'd1);

    // Out-of-range write and read on the DEPTH=6 instance
    drive(1'b1, 1'b1, 3'd7, 8'h99, 1'b1, 3'd6, 1'b0); cycle();
    chk("tp_oor_err", 32'(err_addr6), 32'd1);
    chk("tp_oor_data", 32'(rd_data6), 32'd0);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0); cycle();
    chk("tp_oor_pulse", 32'(err_addr6), 32'd0);

    // Back-to-back reads with a reset pulse mid-stream
    for (int i = 0; i < 12; i++) begin
      drive((i != 6), (i < 4), 3'(i), 8'(8'hC0 + i), 1'b1, 3'(i % 4), 1'b0); cycle();
      if (i == 6) chk("tp_midreset_valid", 32'(rd_valid8), 32'd0);
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            8'($urandom), $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) rd_addr = wr_addr;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
